// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch stage sitting in front of the 1024x16 program ROM.
// It drives the ROM address/enable, soaks up the ROM's one-cycle read
// latency and holds fetched words in a two-entry queue that decode drains
// through a valid/ready handshake. Branch redirects flush the queue and
// drop the read that is in flight; fetching outside the ROM produces a
// single fault marker and parks the fetcher until the next redirect.

module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h2000,
  parameter logic [15:0] ROM_BASE = 16'h2000,
  parameter int          ROM_SIZE = 1024,
  parameter int          QDEPTH   = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_rom_ce,
  output logic [15:0] o_rom_addr,
  input  logic [15:0] i_rom_data,
  output logic        o_valid,
  output logic [15:0] o_instr,
  output logic [15:0] o_pc,
  output logic        o_fault,
  input  logic        i_ready,
  input  logic        i_jmp,
  input  logic [15:0] i_jmp_addr
);

  // One past the last ROM word, widened so ROM_BASE+ROM_SIZE cannot wrap.
  localparam logic [16:0] ROM_END = {1'b0, ROM_BASE} + 17'(ROM_SIZE);

  // Fetch pointer and the halt flag raised after a faulting fetch
  logic [15:0] pc;
  logic        halted;

  // Bookkeeping for the read issued last cycle, whose data arrives now
  logic        inflight;
  logic [15:0] inflight_pc;
  logic        inflight_fault;

  // Two-entry circular queue toward decode
  logic [1:0][15:0] q_instr;
  logic [1:0][15:0] q_pc;
  logic [1:0]       q_fault;
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;

  // Handshake and control terms shared by both state blocks
  logic       pop;
  logic       issue;
  logic       wr_en;
  logic       pc_fault;
  logic [2:0] occ;
  logic [2:0] occ_after_pop;

  // Decode sees the head slot directly; all of these come straight from flops.
  assign o_valid    = (count != 2'd0);
  assign o_instr    = q_instr[rd_ptr];
  assign o_pc       = q_pc[rd_ptr];
  assign o_fault    = q_fault[rd_ptr];
  assign o_rom_addr = pc;
  assign o_rom_ce   = issue;

  // Work out whether decode pops, whether a new read may be issued without
  // risking a queue overflow, and whether the current pc lies outside the ROM.
  // A redirect suppresses both the pop and the issue in its own cycle, and
  // the word returning during a redirect is never written.
  always_comb begin
    pop           = o_valid && i_ready && !i_jmp;
    occ           = {1'b0, count} + {2'b00, inflight};
    occ_after_pop = occ - {2'b00, pop};
    issue         = !i_rst && !i_jmp && !halted && (occ_after_pop < 3'(QDEPTH));
    pc_fault      = (pc < ROM_BASE) || ({1'b0, pc} >= ROM_END);
    wr_en         = inflight && !i_jmp;
  end

  // Advance the fetch pointer on every issue, freeze it once an out-of-range
  // address has been sent down the pipe, and reload it from the redirect
  // target. The in-flight tag records what the returning word belongs to.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pc             <= RESET_PC;
      halted         <= 1'b0;
      inflight       <= 1'b0;
      inflight_pc    <= 16'h0000;
      inflight_fault <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc    <= pc;
        inflight_fault <= pc_fault;
      end
      if (i_jmp) begin
        pc     <= i_jmp_addr;
        halted <= 1'b0;
      end else if (issue) begin
        if (pc_fault) begin
          halted <= 1'b1;
        end else begin
          pc <= pc + 16'h0001;
        end
      end
    end
  end

  // Queue the returning word (or a zeroed fault marker) at the tail and
  // retire the head on a pop. A redirect empties the queue; stale payloads
  // may remain in the slots but are hidden because count is zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      q_instr <= '0;
      q_pc    <= '0;
      q_fault <= '0;
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      count   <= 2'd0;
    end else if (i_jmp) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (wr_en) begin
        q_instr[wr_ptr] <= inflight_fault ? 16'h0000 : i_rom_data;
        q_pc[wr_ptr]    <= inflight_pc;
        q_fault[wr_ptr] <= inflight_fault;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({wr_en, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// Drives the fetch unit against a behavioural ROM and a program-order
// reference model: the model remembers which addresses should have been
// fetched and when, and expects decode to see them in order two cycles
// after their issue, restarting at every redirect target.

module tb_fetch_unit;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        o_rom_ce;
  logic [15:0] o_rom_addr;
  logic [15:0] i_rom_data = 16'h0000;
  logic        o_valid;
  logic [15:0] o_instr;
  logic [15:0] o_pc;
  logic        o_fault;
  logic        i_ready = 1'b0;
  logic        i_jmp = 1'b0;
  logic [15:0] i_jmp_addr = 16'h0000;

  fetch_unit dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .o_rom_ce   (o_rom_ce),
    .o_rom_addr (o_rom_addr),
    .i_rom_data (i_rom_data),
    .o_valid    (o_valid),
    .o_instr    (o_instr),
    .o_pc       (o_pc),
    .o_fault    (o_fault),
    .i_ready    (i_ready),
    .i_jmp      (i_jmp),
    .i_jmp_addr (i_jmp_addr)
  );

  // Free-running clock, period 10
  always #5 i_clk = ~i_clk;

  logic [15:0] mem [1024];

  function automatic bit in_rom(input logic [15:0] a);
    return (a >= 16'h2000) && (a < 16'h2400);
  endfunction

  function automatic logic [15:0] rom_word(input logic [15:0] a);
    logic [15:0] off;
    off = a - 16'h2000;
    return mem[off[9:0]];
  endfunction

  // Synchronous ROM: data for an enabled in-range read shows up next cycle,
  // otherwise the output keeps whatever it held before.
  always @(posedge i_clk) begin
    if (o_rom_ce && in_rom(o_rom_addr)) i_rom_data <= rom_word(o_rom_addr);
  end

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  // Reference model: ordered list of fetched-but-not-consumed addresses
  typedef struct {
    logic [15:0] pc;
    int          cyc;
  } ent_t;
  ent_t        mq[$];
  logic [15:0] m_fetch_pc = 16'h2000;
  bit          m_halted = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    m_fetch_pc = 16'h2000;
    m_halted   = 1'b0;
  endtask

  // Compare this cycle's outputs with the model, then advance the model.
  task automatic modelCheck();
    bit exp_valid;
    bit exp_pop;
    bit exp_issue;
    exp_valid = (mq.size() > 0) && (mq[0].cyc <= cyc - 2);
    exp_pop   = exp_valid && i_ready && !i_jmp;
    exp_issue = !i_jmp && !m_halted && ((mq.size() - int'(exp_pop)) < 2);
    checkOutput("valid", {31'b0, o_valid}, {31'b0, exp_valid});
    checkOutput("rom_ce", {31'b0, o_rom_ce}, {31'b0, exp_issue});
    if (exp_issue) checkOutput("rom_addr", {16'b0, o_rom_addr}, {16'b0, m_fetch_pc});
    if (exp_valid) begin
      checkOutput("head_pc", {16'b0, o_pc}, {16'b0, mq[0].pc});
      checkOutput("head_fault", {31'b0, o_fault}, {31'b0, !in_rom(mq[0].pc)});
      checkOutput("head_instr", {16'b0, o_instr},
                  {16'b0, in_rom(mq[0].pc) ? rom_word(mq[0].pc) : 16'h0000});
    end
    if (exp_pop) void'(mq.pop_front());
    if (exp_issue) begin
      mq.push_back('{pc: m_fetch_pc, cyc: cyc});
      if (!in_rom(m_fetch_pc)) m_halted = 1'b1;
      else m_fetch_pc = m_fetch_pc + 16'h0001;
    end
    if (i_jmp) begin
      mq.delete();
      m_fetch_pc = i_jmp_addr;
      m_halted   = 1'b0;
    end
  endtask

  // One clock cycle: set inputs away from the active edge, then sample.
  task automatic applyStimulus(input bit ready, input bit jmp, input logic [15:0] addr);
    @(negedge i_clk);
    i_rst      = 1'b0;
    i_ready    = ready;
    i_jmp      = jmp;
    i_jmp_addr = addr;
    #1;
    modelCheck();
    cyc++;
  endtask

  task automatic doReset();
    @(negedge i_clk);
    i_rst   = 1'b1;
    i_jmp   = 1'b0;
    i_ready = 1'b0;
    modelReset();
    @(negedge i_clk);
    @(negedge i_clk);
    #1;
    checkOutput("rst_valid", {31'b0, o_valid}, 32'd0);
    checkOutput("rst_fault", {31'b0, o_fault}, 32'd0);
    checkOutput("rst_instr", {16'b0, o_instr}, 32'h0);
    checkOutput("rst_pc", {16'b0, o_pc}, 32'h0);
    checkOutput("rst_ce", {31'b0, o_rom_ce}, 32'd0);
    checkOutput("rst_addr", {16'b0, o_rom_addr}, 32'h2000);
  endtask

  task automatic randomCycles(input int n);
    bit          rdy;
    bit          jmp;
    logic [15:0] tgt;
    int          sel;
    for (int i = 0; i < n; i++) begin
      rdy = ($urandom_range(0, 9) < 7);
      jmp = ($urandom_range(0, 19) == 0);
      sel = $urandom_range(0, 7);
      if (sel == 0) tgt = 16'h23F0 + 16'($urandom_range(0, 15));
      else if (sel == 1) tgt = 16'($urandom);
      else tgt = 16'h2000 + 16'($urandom_range(0, 1023));
      applyStimulus(rdy, jmp, tgt);
    end
  endtask

  int issues;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);

    // Reset release with decode always ready: one word per cycle
    doReset();
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 1'b0, 16'h0);
      if (k == 0) begin
        checkOutput("t1_first_ce", {31'b0, o_rom_ce}, 32'd1);
        checkOutput("t1_first_addr", {16'b0, o_rom_addr}, 32'h2000);
      end
      if (k >= 2) begin
        checkOutput("t1_valid", {31'b0, o_valid}, 32'd1);
        checkOutput("t1_pc", {16'b0, o_pc}, 32'h2000 + 32'(k - 2));
        checkOutput("t1_instr", {16'b0, o_instr}, {16'b0, mem[k - 2]});
      end
    end

    // Decode stalled from the start: exactly two fetches fill the queue
    doReset();
    issues = 0;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b0, 1'b0, 16'h0);
      if (o_rom_ce) issues++;
    end
    checkOutput("t2_issues", 32'(issues), 32'd2);
    checkOutput("t2_full_head", {16'b0, o_pc}, 32'h2000);
    applyStimulus(1'b1, 1'b0, 16'h0);
    checkOutput("t2_resume_ce", {31'b0, o_rom_ce}, 32'd1);
    checkOutput("t2_resume_addr", {16'b0, o_rom_addr}, 32'h2002);
    checkOutput("t2_pop0", {16'b0, o_pc}, 32'h2000);
    applyStimulus(1'b1, 1'b0, 16'h0);
    checkOutput("t2_pop1", {16'b0, o_pc}, 32'h2001);
    checkOutput("t2_pop1_instr", {16'b0, o_instr}, {16'b0, mem[1]});

    // Redirect with a queued word and a read in flight
    doReset();
    applyStimulus(1'b0, 1'b0, 16'h0);
    applyStimulus(1'b0, 1'b0, 16'h0);
    applyStimulus(1'b1, 1'b1, 16'h2100);
    checkOutput("t3_jmp_ce", {31'b0, o_rom_ce}, 32'd0);
    applyStimulus(1'b1, 1'b0, 16'h0);
    checkOutput("t3_j1_addr", {16'b0, o_rom_addr}, 32'h2100);
    checkOutput("t3_j1_valid", {31'b0, o_valid}, 32'd0);
    applyStimulus(1'b1, 1'b0, 16'h0);
    checkOutput("t3_j2_valid", {31'b0, o_valid}, 32'd0);
    applyStimulus(1'b1, 1'b0, 16'h0);
    checkOutput("t3_j3_valid", {31'b0, o_valid}, 32'd1);
    checkOutput("t3_j3_pc", {16'b0, o_pc}, 32'h2100);

    // Running off the end of the ROM
    applyStimulus(1'b1, 1'b1, 16'h23FF);
    applyStimulus(1'b1, 1'b0, 16'h0);
    applyStimulus(1'b1, 1'b0, 16'h0);
    applyStimulus(1'b1, 1'b0, 16'h0);
    checkOutput("t4_last_pc", {16'b0, o_pc}, 32'h23FF);
    checkOutput("t4_last_instr", {16'b0, o_instr}, {16'b0, mem[1023]});
    checkOutput("t4_last_fault", {31'b0, o_fault}, 32'd0);
    applyStimulus(1'b1, 1'b0, 16'h0);
    checkOutput("t4_fault_pc", {16'b0, o_pc}, 32'h2400);
    checkOutput("t4_fault_flag", {31'b0, o_fault}, 32'd1);
    checkOutput("t4_fault_instr", {16'b0, o_instr}, 32'h0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0, 16'h0);
      checkOutput("t4_halted_ce", {31'b0, o_rom_ce}, 32'd0);
    end
    applyStimulus(1'b1, 1'b1, 16'h2000);
    applyStimulus(1'b1, 1'b0, 16'h0);
    checkOutput("t4_restart_ce", {31'b0, o_rom_ce}, 32'd1);
    checkOutput("t4_restart_addr", {16'b0, o_rom_addr}, 32'h2000);

    // Back-to-back redirects: the second target wins
    applyStimulus(1'b1, 1'b1, 16'h2150);
    applyStimulus(1'b1, 1'b1, 16'h2200);
    applyStimulus(1'b1, 1'b0, 16'h0);
    applyStimulus(1'b1, 1'b0, 16'h0);
    applyStimulus(1'b1, 1'b0, 16'h0);
    checkOutput("b2b_pc", {16'b0, o_pc}, 32'h2200);

    // Long random run against the model
    randomCycles(10000);

    // Asynchronous reset while the queue holds data
    applyStimulus(1'b0, 1'b1, 16'h2000);
    applyStimulus(1'b0, 1'b0, 16'h0);
    applyStimulus(1'b0, 1'b0, 16'h0);
    applyStimulus(1'b0, 1'b0, 16'h0);
    checkOutput("pre_rst_valid", {31'b0, o_valid}, 32'd1);
    #2;
    i_rst = 1'b1;
    #1;
    checkOutput("async_rst_valid", {31'b0, o_valid}, 32'd0);
    checkOutput("async_rst_ce", {31'b0, o_rom_ce}, 32'd0);
    checkOutput("async_rst_addr", {16'b0, o_rom_addr}, 32'h2000);
    doReset();
    randomCycles(500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
